mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the rv32i instruction-fetch port (IF) and the load/store port (D).
//  Sits between the core datapath and the memory; one transaction in flight at a time.
//  Round-robin arbitration on contention; response timeout watchdog.
// PARAMETERS
//  ADDR_W      32  address width, both ports and memory
//  DATA_W      32  data width; byte enables are DATA_W/8 bits
//  TIMEOUT     15  max cycles in WAIT without mem_rvalid before error completion (>=1)
//  D_FIRST     1   1: D wins the first contention after reset; 0: IF wins
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       synchronous, active-high
//  if_req       in   1       fetch request; held with if_addr until if_gnt
//  if_addr      in   ADDR_W  fetch address
//  if_gnt       out  1       fetch request accepted (this cycle)
//  if_rvalid    out  1       fetch data valid (1-cycle pulse)
//  if_rdata     out  DATA_W  fetch data
//  d_req        in   1       load/store request; held with payload until d_gnt
//  d_we         in   1       1 = store, 0 = load
//  d_addr       in   ADDR_W  load/store address
//  d_wdata      in   DATA_W  store data
//  d_be         in   DATA_W/8 store byte enables
//  d_gnt        out  1       load/store request accepted
//  d_rvalid     out  1       load data / store ack valid (1-cycle pulse)
//  d_rdata      out  DATA_W  load data (0 for store ack)
//  mem_req      out  1       memory request; held until mem_gnt
//  mem_we       out  1       memory write enable
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_be       out  DATA_W/8 memory byte enables
//  mem_gnt      in   1       memory accepted request
//  mem_rvalid   in   1       memory response (read data or write ack)
//  mem_rdata    in   DATA_W  memory read data
//  err          out  1       1-cycle pulse: timeout or stray mem_rvalid
// BEHAVIOUR
//  FSM IDLE -> ISSUE -> WAIT -> IDLE. Reset: IDLE, all outputs 0, last_owner = D_FIRST ? IF : D.
//  IDLE: if_gnt/d_gnt combinational. Only one req: grant it. Both: grant port != last_owner.
//   On grant: latch we/addr/wdata/be (IF: we=0, be=all-1s), owner <= granted, last_owner <= granted, -> ISSUE.
//  ISSUE: mem_req=1, mem_* driven from latched regs (stable). mem_gnt=1 -> WAIT, timer cleared.
//  WAIT: mem_req=0. mem_rvalid=1 -> owner's x_rvalid=1 same cycle, x_rdata=mem_rdata (D store: 0), -> IDLE.
//   Timer counts cycles in WAIT; reaching TIMEOUT without mem_rvalid -> owner x_rvalid=1, x_rdata=0, err=1, -> IDLE.
//  Non-owner rvalid and both gnts never asserted outside IDLE; gnts never both 1.
//  Latency: req seen in IDLE cycle N -> mem_req cycle N+1; best-case rvalid cycle N+2 (mem_gnt N+1, rvalid N+2).
//  Back-to-back: new grant possible in the IDLE cycle after completion (min 3-cycle issue interval).
//  mem_rvalid in IDLE or ISSUE: ignored (no x_rvalid), err=1 pulse.
//  mem_rvalid same cycle as timeout expiry: response wins, err=0.
//  Req dropped before gnt: allowed, no transaction. Reset mid-transaction: -> IDLE next edge, in-flight response discarded.
// TESTING
//  1 IF only: if_req, addr 0x100; mem_gnt same cycle, rvalid next with 0xDEADBEEF -> if_rvalid 1 cycle, if_rdata=0xDEADBEEF.
//  2 Contention after reset (D_FIRST=1): both req -> d_gnt first, then if_gnt on next IDLE; repeat -> alternates D, IF, D, IF.
//  3 Store: d_we=1, addr 0x200, wdata 0x12345678, be 4'b0011, mem_gnt delayed 3 cycles -> mem_* stable all 4 cycles, d_rvalid, d_rdata=0.
//  4 Timeout: load granted, never mem_rvalid -> after 15 WAIT cycles d_rvalid=1, d_rdata=0, err=1; next IF served normally.
//  5 Stray mem_rvalid in IDLE -> err pulse, no if_rvalid/d_rvalid.
//  6 Reset asserted in WAIT -> next cycle IDLE, mem_req=0, outputs 0; late mem_rvalid -> err only.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (IF) and load/store (D) ports.
// One transaction in flight, round-robin on contention, response watchdog.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 15,
    parameter bit          D_FIRST = 1'b1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                err_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic        OWN_IF = 1'b0;
    localparam logic        OWN_D  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic              grant_d;
    logic              grant_if;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    // State and latched-request registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            last_q  <= D_FIRST ? OWN_IF : OWN_D;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            timer_q <= timer_d;
        end
    end

    // Next state, arbitration and response routing
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        timer_d     = timer_q;
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;

        // On contention the port that was not served last wins
        grant_d  = d_req_i && (!if_req_i || (last_q == OWN_IF));
        grant_if = if_req_i && !grant_d;

        case (state_q)
            S_IDLE: begin
                err_o = mem_rvalid_i;
                if (grant_d) begin
                    d_gnt_o = 1'b1;
                    owner_d = OWN_D;
                    last_d  = OWN_D;
                    we_d    = d_we_i;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    be_d    = d_be_i;
                    state_d = S_ISSUE;
                end else if (grant_if) begin
                    if_gnt_o = 1'b1;
                    owner_d  = OWN_IF;
                    last_d   = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr_i;
                    wdata_d  = '0;
                    be_d     = '1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                err_o       = mem_rvalid_i;
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                mem_be_o    = be_q;
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                    timer_d = '0;
                end
            end
            S_WAIT: begin
                // A response arriving on the expiry cycle still wins
                if (mem_rvalid_i) begin
                    resp_valid = 1'b1;
                    resp_data  = we_q ? '0 : mem_rdata_i;
                    state_d    = S_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    resp_valid = 1'b1;
                    err_o      = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if_rvalid_o = resp_valid && (owner_q == OWN_IF);
        d_rvalid_o  = resp_valid && (owner_q == OWN_D);
        if_rdata_o  = if_rvalid_o ? resp_data : '0;
        d_rdata_o   = d_rvalid_o ? resp_data : '0;

        if (reset_i) begin
            if_gnt_o    = 1'b0;
            d_gnt_o     = 1'b0;
            if_rvalid_o = 1'b0;
            d_rvalid_o  = 1'b0;
            if_rdata_o  = '0;
            d_rdata_o   = '0;
            err_o       = 1'b0;
        end
    end

endmodule
